// File: rtl/elbeth_pkg.sv
// Shared definitions for the ELBETH hazard/forwarding controller:
// forwarding mux select codes, the zero register and the FSM state encoding.
package elbeth_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int CNT_W = 4;

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/elbeth_hazard_ctrl_if.sv
// ID-stage instruction info in, forwarding selects and pipeline hold/bubble
// controls out, plus FSM debug visibility.
interface elbeth_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    import elbeth_pkg::*;

    // id_valid qualifies every id_* field in the same cycle; there is no ready
    // signal: the controller answers combinationally through the stall_* and
    // bubble_ex outputs, and an ID instruction is consumed on a clock edge
    // only when stall_id_ex, bubble_ex and flush_id are all low.
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_muldiv;
    logic                  flush_id;

    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic                  stall_pc;
    logic                  stall_if_id;
    logic                  stall_id_ex;
    logic                  bubble_ex;
    logic                  busy;

    state_t                dbg_state;
    logic [CNT_W-1:0]      dbg_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_reg_write, id_mem_read, id_muldiv, flush_id,
        input  fwd_a_sel, fwd_b_sel, stall_pc, stall_if_id, stall_id_ex,
               bubble_ex, busy, dbg_state, dbg_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_reg_write, id_mem_read, id_muldiv, flush_id,
        output fwd_a_sel, fwd_b_sel, stall_pc, stall_if_id, stall_id_ex,
               bubble_ex, busy, dbg_state, dbg_cnt
    );

endinterface

// File: rtl/elbeth_fwd_sel.sv
// Forwarding select for one EX operand: EX/MEM result wins over MEM/WB,
// and register zero is never forwarded.
module elbeth_fwd_sel
    import elbeth_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_src,
    input  logic                  ex_uses,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output logic [1:0]            sel
);

    always_comb begin
        sel = FWD_REGFILE;
        if (ex_uses && (ex_src != '0)) begin
            if (mem_reg_write && (mem_rd == ex_src)) begin
                sel = FWD_EXMEM;
            end else if (wb_reg_write && (wb_rd == ex_src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/elbeth_hazard_ctrl.sv
// Hazard and forwarding controller for the ELBETH 5-stage pipeline: shadows
// EX/MEM/WB destination info, drives forwarding selects and stall/bubble controls.
module elbeth_hazard_ctrl
    import elbeth_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,  // 2..16 cycles a mul/div occupies EX
    parameter int REG_ADDR_W    = 5
) (
    input  logic clk,
    input  logic rst,
    elbeth_hazard_ctrl_if.slave hz
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULDIV_CYCLES - 1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  uses_rs;
        logic                  uses_rt;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } ex_shadow_t;

    // Downstream stages only ever feed the comparators with rd/reg_write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } wr_shadow_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ex_shadow_t       ex_q, ex_d;
    wr_shadow_t       mem_q, mem_d;
    wr_shadow_t       wb_q, wb_d;
    ex_shadow_t       id_sh;
    logic             load_use;
    logic             accept;

    assign id_sh = '{
        rs:        hz.id_rs,
        rt:        hz.id_rt,
        uses_rs:   hz.id_uses_rs,
        uses_rt:   hz.id_uses_rt,
        rd:        hz.id_rd,
        reg_write: hz.id_reg_write,
        mem_read:  hz.id_mem_read
    };

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

    always_comb begin
        load_use = (state_q == RUN) && ex_q.mem_read && (ex_q.rd != '0) &&
                   hz.id_valid &&
                   ((hz.id_uses_rs && (hz.id_rs == ex_q.rd)) ||
                    (hz.id_uses_rt && (hz.id_rt == ex_q.rd)));
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ex_d           = ex_q;
        mem_d          = '{rd: ex_q.rd, reg_write: ex_q.reg_write};
        wb_d           = mem_q;
        accept         = 1'b0;
        hz.stall_pc    = 1'b0;
        hz.stall_if_id = 1'b0;
        hz.stall_id_ex = 1'b0;
        hz.bubble_ex   = 1'b0;
        hz.busy        = 1'b0;

        case (state_q)
            RUN: begin
                // A taken branch kills the ID instruction, so a load-use
                // stall on it would be pointless.
                if (hz.flush_id) begin
                    hz.bubble_ex = 1'b1;
                end else if (load_use) begin
                    hz.stall_pc    = 1'b1;
                    hz.stall_if_id = 1'b1;
                    hz.bubble_ex   = 1'b1;
                end
                accept = hz.id_valid && !hz.flush_id && !load_use;
                ex_d   = accept ? id_sh : '0;
                if (accept && hz.id_muldiv) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                hz.stall_pc    = 1'b1;
                hz.stall_if_id = 1'b1;
                hz.stall_id_ex = 1'b1;
                hz.busy        = 1'b1;
                ex_d           = ex_q;
                mem_d          = '0;
                cnt_d          = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    elbeth_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .ex_src        (ex_q.rs),
        .ex_uses       (ex_q.uses_rs),
        .mem_rd        (mem_q.rd),
        .mem_reg_write (mem_q.reg_write),
        .wb_rd         (wb_q.rd),
        .wb_reg_write  (wb_q.reg_write),
        .sel           (hz.fwd_a_sel)
    );

    elbeth_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .ex_src        (ex_q.rt),
        .ex_uses       (ex_q.uses_rt),
        .mem_rd        (mem_q.rd),
        .mem_reg_write (mem_q.reg_write),
        .wb_rd         (wb_q.rd),
        .wb_reg_write  (wb_q.reg_write),
        .sel           (hz.fwd_b_sel)
    );

    assign hz.dbg_state = state_q;
    assign hz.dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_elbeth_hazard_ctrl.sv
// Self-checking bench for elbeth_hazard_ctrl: cycle-by-cycle instruction
// sequences with hand-derived expected output vectors held in a scoreboard queue.
module tb_elbeth_hazard_ctrl;
    import elbeth_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    // Packed as {fwd_a(2), fwd_b(2), stall_pc, stall_if_id, stall_id_ex, bubble_ex, busy}
    logic [8:0] exp_q[$];

    elbeth_hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

    elbeth_hazard_ctrl #(
        .MULDIV_CYCLES (4),
        .REG_ADDR_W    (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [8:0] ev(input logic [1:0] a, input logic [1:0] b,
                                      input logic spc, input logic sif,
                                      input logic sidex, input logic bub,
                                      input logic bsy);
        return {a, b, spc, sif, sidex, bub, bsy};
    endfunction

    function automatic logic [8:0] outs();
        return {hz.fwd_a_sel, hz.fwd_b_sel, hz.stall_pc, hz.stall_if_id,
                hz.stall_id_ex, hz.bubble_ex, hz.busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic instr(input logic v, input int rs, input int rt,
                         input logic urs, input logic urt, input int rd,
                         input logic rw, input logic mr, input logic md);
        hz.id_valid     = v;
        hz.id_rs        = 5'(rs);
        hz.id_rt        = 5'(rt);
        hz.id_uses_rs   = urs;
        hz.id_uses_rt   = urt;
        hz.id_rd        = 5'(rd);
        hz.id_reg_write = rw;
        hz.id_mem_read  = mr;
        hz.id_muldiv    = md;
    endtask

    task automatic nop();
        instr(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // One pipeline cycle: expectation queued at drive time, compared mid-cycle.
    task automatic step(input string tag, input logic [8:0] exp);
        logic [8:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        e = exp_q.pop_front();
        check(tag, 32'(outs()), 32'(e));
        @(posedge clk);
        #1;
        hz.flush_id = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            nop();
            step("drain", '0);
        end
    endtask

    // ---------------- stimulus ----------------
    localparam logic [8:0] V0     = 9'b0;
    localparam logic [8:0] BUSY_V = 9'b0000_11101;
    localparam logic [8:0] LU_V   = 9'b0000_11010;
    localparam logic [8:0] FL_V   = 9'b0000_00010;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        hz.flush_id = 1'b0;
        nop();

        @(negedge clk);
        check("reset_outs", 32'(outs()), 0);
        check("reset_state", 32'(hz.dbg_state), 32'(RUN));
        check("reset_cnt", 32'(hz.dbg_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back ALU dependency: add r3,r1,r2 ; sub r4,r3,r5
        instr(1, 1, 2, 1, 1, 3, 1, 0, 0);  step("b2b_add_id", V0);
        instr(1, 3, 5, 1, 1, 4, 1, 0, 0);  step("b2b_sub_id", V0);
        nop();                              step("b2b_sub_ex", ev(2'b01, 2'b00, 0, 0, 0, 0, 0));
        drain(3 + int'($urandom_range(0, 2)));

        // Distance-2: add r3 ; nop ; or r6,r3,r3
        instr(1, 1, 2, 1, 1, 3, 1, 0, 0);  step("d2_add_id", V0);
        nop();                              step("d2_nop", V0);
        instr(1, 3, 3, 1, 1, 6, 1, 0, 0);  step("d2_or_id", V0);
        nop();                              step("d2_or_ex", ev(2'b10, 2'b10, 0, 0, 0, 0, 0));
        drain(3);

        // Writer of r0 followed by reader of r0: never forwarded
        instr(1, 1, 2, 1, 1, 0, 1, 0, 0);  step("r0_wr_id", V0);
        instr(1, 0, 0, 1, 1, 5, 1, 0, 0);  step("r0_rd_id", V0);
        nop();                              step("r0_rd_ex_d1", V0);
        drain(3);

        // Load-use: lw r2,(r1) ; add r7,r2,r1
        instr(1, 1, 0, 1, 0, 2, 1, 1, 0);  step("lu_lw_id", V0);
        instr(1, 2, 1, 1, 1, 7, 1, 0, 0);  step("lu_stall", LU_V);
        instr(1, 2, 1, 1, 1, 7, 1, 0, 0);  step("lu_release", V0);
        nop();                              step("lu_add_ex", ev(2'b10, 2'b00, 0, 0, 0, 0, 0));
        drain(3);

        // Load-use coinciding with a flush
        instr(1, 1, 0, 1, 0, 2, 1, 1, 0);  step("fl_lw_id", V0);
        instr(1, 2, 1, 1, 1, 7, 1, 0, 0);
        hz.flush_id = 1'b1;                 step("fl_flush", FL_V);
        nop();                              step("fl_after", V0);
        drain(3);

        // mul/div: add r1 ; mul r8,r1,r2 ; add r9,r8,r3 (flush pulse mid-BUSY)
        instr(1, 4, 5, 1, 1, 1, 1, 0, 0);  step("md_add_id", V0);
        instr(1, 1, 2, 1, 1, 8, 1, 0, 1);  step("md_mul_id", V0);
        instr(1, 8, 3, 1, 1, 9, 1, 0, 0);  step("md_busy1", ev(2'b01, 2'b00, 1, 1, 1, 0, 1));
        hz.flush_id = 1'b1;                 step("md_busy2", ev(2'b10, 2'b00, 1, 1, 1, 0, 1));
        instr(1, 8, 3, 1, 1, 9, 1, 0, 0);  step("md_busy3", BUSY_V);
        instr(1, 8, 3, 1, 1, 9, 1, 0, 0);  step("md_cycle4", V0);
        nop();                              step("md_next_ex", ev(2'b01, 2'b00, 0, 0, 0, 0, 0));
        drain(3);

        // Reset during the second BUSY cycle
        instr(1, 1, 2, 1, 1, 8, 1, 0, 1);  step("rb_mul_id", V0);
        instr(1, 8, 3, 1, 1, 9, 1, 0, 0);  step("rb_busy1", BUSY_V);
        #2;
        check("rb_busy2_pre", 32'(outs()), 32'(BUSY_V));
        check("rb_busy2_state", 32'(hz.dbg_state), 32'(BUSY));
        rst = 1'b1;
        #1;
        check("rb_rst_outs", 32'(outs()), 0);
        check("rb_rst_state", 32'(hz.dbg_state), 32'(RUN));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        instr(1, 1, 0, 1, 0, 2, 1, 1, 0);  step("rb_lw_id", V0);
        instr(1, 2, 1, 1, 1, 7, 1, 0, 0);  step("rb_lu_stall", LU_V);
        instr(1, 2, 1, 1, 1, 7, 1, 0, 0);  step("rb_release", V0);
        nop();                              step("rb_add_ex", ev(2'b10, 2'b00, 0, 0, 0, 0, 0));
        drain(2);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/elbeth_hazard_ctrl.md
Name: elbeth_hazard_ctrl

Overview:
- Hazard and forwarding controller for the ELBETH 5-stage pipeline.
- Keeps a shadow copy of the destination-register info for the EX, MEM and WB stages.
- Drives the 2-bit selects of the two EX-stage operand forwarding muxes (3-to-1, 32-bit): 00 = regfile/ID-EX value, 01 = EX/MEM result, 10 = MEM/WB result.
- Generates pipeline stall/bubble controls for load-use hazards and multi-cycle mul/div occupancy of EX.

Parameters:
- MULDIV_CYCLES, 4, total cycles a mul/div instruction occupies EX; legal range 2..16.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs, id_rt  in  REG_ADDR_W  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1  the ID instruction reads rs / rt.
- id_rd  in  REG_ADDR_W  destination register of the ID instruction.
- id_reg_write  in  1  the ID instruction writes the regfile.
- id_mem_read  in  1  the ID instruction is a load.
- id_muldiv  in  1  the ID instruction is a multi-cycle mul/div.
- flush_id  in  1  taken branch/jump: kill the ID instruction.
- fwd_a_sel, fwd_b_sel  out  2  select codes for the operand A / B forwarding muxes.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold the IF/ID register.
- stall_id_ex  out  1  hold the ID/EX register.
- bubble_ex  out  1  load a NOP into ID/EX on this edge.
- busy  out  1  mul/div sequencing is in progress.

Behaviour:
- Shadow registers per stage: rs, rt, uses_rs, uses_rt, rd, reg_write, mem_read (EX only). Bubble = all-zero fields.
- Reset (async, any state, including mid-mul/div): state=RUN, cnt=0, all shadows cleared to bubble. All outputs then read 0 (fwd sels 00).
- fwd_a_sel (combinational from registered shadows); fwd_b_sel uses ex_rt/ex_uses_rt identically:
  - 01 if ex_uses_rs, mem_reg_write, mem_rd==ex_rs, and ex_rs!=0;
  - else 10 if ex_uses_rs, wb_reg_write, wb_rd==ex_rs, and ex_rs!=0;
  - else 00.
  - EX/MEM has priority over MEM/WB. Code 11 is never produced.
- load_use (combinational), evaluated only in RUN: ex_mem_read && ex_rd!=0 && id_valid && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)).
- FSM states RUN, BUSY; cnt is 4 bits.
- In RUN:
  - flush_id=1: bubble_ex=1; stall_pc, stall_if_id and stall_id_ex all 0. Flush beats load_use.
  - else load_use=1: stall_pc=stall_if_id=1, bubble_ex=1, stall_id_ex=0. Exactly one bubble per load; the dependent instruction later gets forwarding select 10.
  - Shadow advance: ex <= bubble if (flush_id || load_use || !id_valid), otherwise ID fields; mem <= ex; wb <= mem.
  - If ID fields are accepted and id_muldiv=1: next state BUSY, cnt <= MULDIV_CYCLES-1.
- In BUSY:
  - stall_pc, stall_if_id, stall_id_ex and busy are all 1; bubble_ex=0.
  - Shadows: ex holds; mem <= bubble; wb <= mem.
  - cnt decrements each cycle; when cnt==1, next state is RUN.
  - flush_id and load_use are ignored; the front end is frozen.
  - The mul/div instruction resides in EX for exactly MULDIV_CYCLES cycles; stalls are asserted for MULDIV_CYCLES-1 of them.
- Forwarding stays live during BUSY: the mul/div operands can still pick up MEM/WB results as older instructions drain.
- All stall/bubble outputs are combinational from state and inputs; there is no added latency.

Decomposition:
- Shared package elbeth_pkg:
  - FWD_REGFILE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - REG_ZERO=5'd0;
  - state encodings RUN/BUSY.
- One natural sub-module, elbeth_fwd_sel: the pure combinational comparator producing one 2-bit select. It is instantiated twice (operands A and B).

Test Plan:
- Back-to-back ALU dependency: add r3 then sub r4,r3,r5 → in the cycle sub is in EX, fwd_a_sel=01, fwd_b_sel=00, no stall.
- Distance-2 dependency, plus an r0 case: add r3; nop; or r6,r3,r3 → both sels=10. A writer with rd=0 followed by a reader of r0 → sels stay 00.
- Load-use: lw r2 then add r7,r2,r1 → exactly one cycle with stall_pc=stall_if_id=bubble_ex=1, then fwd_a_sel=10 when add is in EX.
- Load-use coinciding with flush_id=1 → bubble_ex=1, stall_pc=0, stall_if_id=0.
- MULDIV_CYCLES=4: mul enters EX → busy and all stalls high for 3 cycles, ID/EX held. In cycle 4 they drop, and the next instruction enters EX on the following edge. A flush_id pulse during BUSY has no effect.
- Assert rst during the 2nd BUSY cycle → all outputs 0 immediately, state RUN. The first instruction after reset is accepted with no residual stall.
